safelock_fsm: RTL

// - Master control FSM of the smart safelock. Consumes debounced keypad events;

---
 rtl/safelock_pkg.sv | 13 +
 rtl/safelock_timer.sv | 28 ++
 rtl/safelock_fsm.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/safelock_pkg.sv
// rtl/safelock_pkg.sv - shared state encoding for the safelock FSM and state_decoder
package safelock_pkg;

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_ENTRY    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_ERROR    = 3'd3,
    S_LOCKOUT  = 3'd4,
    S_SET_CODE = 3'd5
  } state_t;

endpackage

// File: rtl/safelock_timer.sv
// rtl/safelock_timer.sv - loadable down-counter shared by the ERROR and LOCKOUT waits
module safelock_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_load,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Holds at zero once expired so the count never wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= i_load;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  // Fires in the last cycle of the wait, so the state leaves after exactly i_load clocks.
  assign o_done = (r_count == W'(1));

endmodule

// File: rtl/safelock_fsm.sv
// rtl/safelock_fsm.sv - master control FSM of the smart safelock
module safelock_fsm
  import safelock_pkg::*;
#(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    ERROR_CYCLES   = 50_000_000,
  parameter int                    LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_digit,
  input  logic       i_enter,
  input  logic       i_lock,
  input  logic       i_set,
  output logic [2:0] o_state,
  output logic       o_unlock,
  output logic       o_alarm,
  output logic [3:0] o_digit_cnt
);

  localparam int BW   = 4 * CODE_LEN;
  localparam int TMAX = (ERROR_CYCLES > LOCKOUT_CYCLES) ? ERROR_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_TRIES + 1);
  localparam logic [3:0]    CNT_FULL  = 4'(CODE_LEN);
  localparam logic [RW-1:0] TRIES_MAX = RW'(MAX_TRIES);

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_buf, w_buf_nxt;
  logic [BW-1:0] r_code, w_code_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [RW-1:0] r_tries, w_tries_nxt, w_tries_inc;
  logic          r_unlock, r_alarm;
  logic          w_digit_ok, w_match;
  logic          w_tmr_start, w_tmr_done;
  logic [TW-1:0] w_tmr_load;

  assign w_digit_ok  = i_key_valid && (i_key_digit <= 4'd9) && (r_cnt < CNT_FULL);
  assign w_match     = (r_cnt == CNT_FULL) && (r_buf == r_code);
  assign w_tries_inc = (r_tries >= TRIES_MAX) ? r_tries : r_tries + RW'(1);

  safelock_timer #(.W(TW)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_tmr_start),
    .i_load  (w_tmr_load),
    .o_done  (w_tmr_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_tries_nxt = r_tries;
    w_code_nxt  = r_code;
    w_tmr_start = 1'b0;
    w_tmr_load  = TW'(ERROR_CYCLES);
    case (r_state)
      S_LOCKED: begin
        if (w_digit_ok) begin
          w_buf_nxt   = BW'({r_buf, i_key_digit});
          w_cnt_nxt   = r_cnt + 4'd1;
          w_state_nxt = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (i_lock) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_LOCKED;
        end else if (i_enter) begin
          w_buf_nxt = '0;
          w_cnt_nxt = '0;
          if (w_match) begin
            w_tries_nxt = '0;
            w_state_nxt = S_UNLOCKED;
          end else begin
            w_tries_nxt = w_tries_inc;
            w_tmr_start = 1'b1;
            if (w_tries_inc >= TRIES_MAX) begin
              w_tmr_load  = TW'(LOCKOUT_CYCLES);
              w_state_nxt = S_LOCKOUT;
            end else begin
              w_state_nxt = S_ERROR;
            end
          end
        end else if (w_digit_ok) begin
          w_buf_nxt = BW'({r_buf, i_key_digit});
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_ERROR: begin
        if (w_tmr_done) w_state_nxt = S_LOCKED;
      end
      S_LOCKOUT: begin
        if (w_tmr_done) begin
          w_tries_nxt = '0;
          w_state_nxt = S_LOCKED;
        end
      end
      S_UNLOCKED: begin
        if (i_lock) begin
          w_state_nxt = S_LOCKED;
        end else if (i_set) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SET_CODE;
        end
      end
      S_SET_CODE: begin
        if (i_lock) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_LOCKED;
        end else if (i_enter) begin
          if (r_cnt == CNT_FULL) w_code_nxt = r_buf;
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_UNLOCKED;
        end else if (w_digit_ok) begin
          w_buf_nxt = BW'({r_buf, i_key_digit});
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_buf_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_LOCKED;
      end
    endcase
  end

  // Actuator and alarm are registered from the next state so they move with o_state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_LOCKED;
      r_buf    <= '0;
      r_cnt    <= '0;
      r_tries  <= '0;
      r_code   <= DEFAULT_CODE;
      r_unlock <= 1'b0;
      r_alarm  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_buf    <= w_buf_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tries  <= w_tries_nxt;
      r_code   <= w_code_nxt;
      r_unlock <= (w_state_nxt == S_UNLOCKED) || (w_state_nxt == S_SET_CODE);
      r_alarm  <= (w_state_nxt == S_LOCKOUT);
    end
  end

  assign o_state     = r_state;
  assign o_unlock    = r_unlock;
  assign o_alarm     = r_alarm;
  assign o_digit_cnt = r_cnt;

endmodule
